// File: rtl/uc_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states
// and the datapath mux-select codes driven by the output decoder.
package uc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        REXEC  = 4'd6,
        RWB    = 4'd7,
        BEQ    = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/uc_out_decode.sv
// Moore output decode: registered state (plus memReady for the handshake-driven
// strobes) to datapath controls. JUMP outputs exist only when UC_JUMP_EN is defined.
module uc_out_decode
    import uc_pkg::*;
(
    input  logic [3:0] state,
    input  logic       memReady,
    input  logic       en,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memtoReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       retire
);

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memtoReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALUOP_ADD;
        pcSrc       = PCSRC_ALU;
        retire      = 1'b0;
        // en low (reset) leaves every control at its idle value
        if (en) begin
            case (state)
                FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = SRCB_FOUR;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                DECODE: aluSrcB = SRCB_IMMSH;
                MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                MEMWB: begin
                    regWrite = 1'b1;
                    memtoReg = 1'b1;
                    retire   = 1'b1;
                end
                MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                    retire   = memReady;
                end
                REXEC: begin
                    aluSrcA = 1'b1;
                    aluOp   = ALUOP_FUNCT;
                end
                RWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                    retire   = 1'b1;
                end
                BEQ: begin
                    aluSrcA     = 1'b1;
                    aluOp       = ALUOP_SUB;
                    pcWriteCond = 1'b1;
                    pcSrc       = PCSRC_ALUOUT;
                    retire      = 1'b1;
                end
                ADDIEX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = SRCB_IMM;
                end
                ADDIWB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
`ifdef UC_JUMP_EN
                JUMP: begin
                    pcWrite = 1'b1;
                    pcSrc   = PCSRC_JUMP;
                    retire  = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle MIPS control unit: state register, next-state logic and retired
// instruction counter. Define UC_JUMP_EN to add the j instruction (state JUMP).
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memtoReg,
    output logic             regDst,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSrc,
    output logic             illegalOp,
    output logic             retire,
    output logic [CNT_W-1:0] instrCount,
    output logic [3:0]       state
);

    state_t           stateReg;
    state_t           stateNext;
    logic [CNT_W-1:0] countReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= FETCH;
            countReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (retire) begin
                countReg <= countReg + 1'b1;
            end
        end
    end

    always_comb begin
        stateNext = FETCH;
        illegalOp = 1'b0;
        case (stateReg)
            FETCH:  stateNext = memReady ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:     stateNext = REXEC;
                    OP_LW, OP_SW: stateNext = MEMADR;
                    OP_BEQ:       stateNext = BEQ;
                    OP_ADDI:      stateNext = ADDIEX;
`ifdef UC_JUMP_EN
                    OP_J:         stateNext = JUMP;
`endif
                    default: begin
                        stateNext = FETCH;
                        illegalOp = ~rst;
                    end
                endcase
            end
            // opcode is held stable from DECODE, so it still selects lw vs sw here
            MEMADR: stateNext = (opcode == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  stateNext = memReady ? MEMWB : MEMRD;
            MEMWR:  stateNext = memReady ? FETCH : MEMWR;
            REXEC:  stateNext = RWB;
            ADDIEX: stateNext = ADDIWB;
            default: stateNext = FETCH;
        endcase
    end

    uc_out_decode u_out_decode (
        .state       (stateReg),
        .memReady    (memReady),
        .en          (~rst),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memtoReg    (memtoReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSrc       (pcSrc),
        .retire      (retire)
    );

    assign instrCount = countReg;
    assign state      = stateReg;

endmodule

// File: tb/tb_uc_multiciclo.sv
// Directed bench for uc_multiciclo (CNT_W=4 so the counter wrap is reachable);
// expected state walks and control words are written out by hand per opcode.
module tb_uc_multiciclo;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [5:0]          opcode;
    logic                memReady;
    logic                pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic                memtoReg, regDst, regWrite, aluSrcA, illegalOp, retire;
    logic [1:0]          aluSrcB, aluOp, pcSrc;
    logic [TB_CNT_W-1:0] instrCount;
    logic [3:0]          state;
    logic [16:0]         ctrlObs;

    int                  vecCount = 0;
    int                  errCount = 0;
    logic [TB_CNT_W-1:0] expCount = '0;
    int                  expQ[$];
    int                  rdyQ[$];

    always #5 clk = ~clk;

    uc_multiciclo #(.CNT_W(TB_CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .memReady    (memReady),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .iorD        (iorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .irWrite     (irWrite),
        .memtoReg    (memtoReg),
        .regDst      (regDst),
        .regWrite    (regWrite),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .aluOp       (aluOp),
        .pcSrc       (pcSrc),
        .illegalOp   (illegalOp),
        .retire      (retire),
        .instrCount  (instrCount),
        .state       (state)
    );

    assign ctrlObs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memtoReg,
                      regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSrc, retire};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hand-written control table, one row per state
    function automatic logic [16:0] ctrlExp(input int s, input logic rdy);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, ret;
        logic [1:0] sb, op, ps;
        pw = 1'b0; pwc = 1'b0; iord = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0;
        m2r = 1'b0; rd = 1'b0; rw = 1'b0; sa = 1'b0; ret = 1'b0;
        sb = 2'b00; op = 2'b00; ps = 2'b00;
        case (s)
            0:  begin mr = 1'b1; sb = 2'b01; irw = rdy; pw = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1'b1; sb = 2'b10; end
            3:  begin mr = 1'b1; iord = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; ret = 1'b1; end
            5:  begin mw = 1'b1; iord = 1'b1; ret = rdy; end
            6:  begin sa = 1'b1; op = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; ret = 1'b1; end
            8:  begin sa = 1'b1; op = 2'b01; pwc = 1'b1; ps = 2'b01; ret = 1'b1; end
            9:  begin sa = 1'b1; sb = 2'b10; end
            10: begin rw = 1'b1; ret = 1'b1; end
            11: begin pw = 1'b1; ps = 2'b10; ret = 1'b1; end
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, op, ps, ret};
    endfunction

    function automatic logic isLegal(input logic [5:0] op);
        logic ok;
        ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
             (op == 6'b000100) || (op == 6'b001000);
`ifdef UC_JUMP_EN
        ok = ok || (op == 6'b000010);
`endif
        return ok;
    endfunction

    // Walks expQ/rdyQ one cycle per entry; entered and left at posedge+1
    task automatic runSeq(input logic [5:0] op, input bit counts);
        for (int i = 0; i < expQ.size(); i++) begin
            opcode   = op;
            memReady = (rdyQ[i] != 0);
            @(negedge clk);
            chk($sformatf("state[%0d] op=%b", i, op), 32'(state), 32'(expQ[i]));
            chk($sformatf("ctrl s%0d op=%b", expQ[i], op), 32'(ctrlObs),
                32'(ctrlExp(expQ[i], memReady)));
            chk($sformatf("illegalOp s%0d op=%b", expQ[i], op), 32'(illegalOp),
                32'((expQ[i] == 1) && !isLegal(op)));
            @(posedge clk);
            #1;
        end
        if (counts) expCount = expCount + 1'b1;
        chk($sformatf("instrCount op=%b", op), 32'(instrCount), 32'(expCount));
    endtask

    task automatic doReset(input int n);
        rst      = 1'b1;
        memReady = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst ctrl", 32'(ctrlObs), 32'h0);
            chk("rst illegalOp", 32'(illegalOp), 32'h0);
            @(posedge clk);
            #1;
        end
        chk("rst state", 32'(state), 32'h0);
        chk("rst instrCount", 32'(instrCount), 32'h0);
        rst      = 1'b0;
        expCount = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        memReady = 1'b1;
        opcode   = 6'b000000;
        @(posedge clk);
        #1;
        doReset(2);

        // R-type
        expQ = '{0, 1, 6, 7};          rdyQ = '{1, 1, 1, 1};
        runSeq(6'b000000, 1'b1);
        // lw with a 3-cycle read stall
        expQ = '{0, 1, 2, 3, 3, 3, 3, 4}; rdyQ = '{1, 1, 1, 0, 0, 0, 1, 1};
        runSeq(6'b100011, 1'b1);
        // sw, no stall then a 1-cycle write stall
        expQ = '{0, 1, 2, 5};          rdyQ = '{1, 1, 1, 1};
        runSeq(6'b101011, 1'b1);
        expQ = '{0, 1, 2, 5, 5};       rdyQ = '{1, 1, 1, 0, 1};
        runSeq(6'b101011, 1'b1);
        // beq
        expQ = '{0, 1, 8};             rdyQ = '{1, 1, 1};
        runSeq(6'b000100, 1'b1);
        // R-type behind a fetch stall
        expQ = '{0, 0, 1, 6, 7};       rdyQ = '{0, 1, 1, 1, 1};
        runSeq(6'b000000, 1'b1);
        // addi
        expQ = '{0, 1, 9, 10};         rdyQ = '{1, 1, 1, 1};
        runSeq(6'b001000, 1'b1);
        // illegal opcode
        expQ = '{0, 1};                rdyQ = '{1, 1};
        runSeq(6'b111111, 1'b0);
`ifdef UC_JUMP_EN
        expQ = '{0, 1, 11};            rdyQ = '{1, 1, 1};
        runSeq(6'b000010, 1'b1);
`else
        expQ = '{0, 1};                rdyQ = '{1, 1};
        runSeq(6'b000010, 1'b0);
`endif

        // reset while stalled in MEMRD abandons the lw
        expQ = '{0, 1, 2, 3};          rdyQ = '{1, 1, 1, 0};
        runSeq(6'b100011, 1'b0);
        doReset(1);

        // 17 beq: 4-bit counter wraps to 1
        for (int k = 0; k < 17; k++) begin
            expQ = '{0, 1, 8};         rdyQ = '{1, 1, 1};
            runSeq(6'b000100, 1'b1);
        end
        chk("wrap instrCount", 32'(instrCount), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/uc_multiciclo.md
Name: uc_multiciclo

Overview:
- Multi-cycle MIPS control unit: a Moore FSM that sequences the shared datapath (PC, IR, register file, ALU, unified memory) over 3–5 cycles per instruction.
- Supports R-type, lw, sw, beq and addi; memory accesses stall on a memory-ready handshake.
- Counts retired instructions and flags illegal opcodes.
- Sits beside the datapath and drives all its mux selects and write enables.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- opcode  input  6  IR[31:26]; stable from DECODE until the instruction retires.
- memReady  input  1  memory completed the current read/write this cycle.
- pcWrite  output  1  unconditional PC load.
- pcWriteCond  output  1  PC load when ALU zero=1 (the datapath does the AND).
- iorD  output  1  memory address select: 0=PC, 1=ALUOut.
- memRead  output  1  memory read request.
- memWrite  output  1  memory write request.
- irWrite  output  1  IR load.
- memtoReg  output  1  register write data select: 1=MDR, 0=ALUOut.
- regDst  output  1  destination register: 1=rd, 0=rt.
- regWrite  output  1  register file write enable.
- aluSrcA  output  1  ALU A select: 0=PC, 1=A register.
- aluSrcB  output  2  ALU B select: 00=B, 01=const 4, 10=sign-extended imm, 11=sign-extended imm<<2.
- aluOp  output  2  00=add, 01=sub, 10=decode funct.
- pcSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target.
- illegalOp  output  1  one-cycle flag: unsupported opcode seen in DECODE.
- retire  output  1  one-cycle pulse on the last cycle of each instruction.
- instrCount  output  CNT_W  retired-instruction count.
- state  output  4  current state, for debug.

Behaviour:
- Reset:
  - rst=1 on a clock edge sets state=FETCH(0) and instrCount=0; it overrides memReady and any transition.
  - While rst=1 every control output, illegalOp and retire are forced to 0.
  - Reset mid-instruction abandons the instruction; it is not counted.
- Output timing: outputs decode from the registered state; only irWrite, pcWrite and retire also depend on memReady. Outputs not listed for a state are 0.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12–15 go to FETCH on the next edge.
- Per-state outputs and transitions:
  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00, irWrite=pcWrite=memReady. Next state is DECODE if memReady, else FETCH.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=00. Next state by opcode:
    - 000000 → REXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BEQ
    - 001000 → ADDIEX
    - any other → FETCH, with illegalOp=1 during this cycle.
  - MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. lw → MEMRD, sw → MEMWR.
  - MEMRD: memRead=1, iorD=1. Stays until memReady, then MEMWB.
  - MEMWB: regWrite=1, memtoReg=1, regDst=0. retire=1, then FETCH.
  - MEMWR: memWrite=1, iorD=1. Stays until memReady; retire=memReady; then FETCH.
  - REXEC: aluSrcA=1, aluSrcB=00, aluOp=10, then RWB.
  - RWB: regWrite=1, regDst=1, memtoReg=0. retire=1, then FETCH.
  - BEQ: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSrc=01. retire=1, then FETCH.
  - ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00, then ADDIWB.
  - ADDIWB: regWrite=1, regDst=0, memtoReg=0. retire=1, then FETCH.
- Latencies with memReady always 1: R-type 4, lw 5, sw 4, beq 3, addi 4 cycles.
- instrCount increments by 1 on each clock edge where retire=1 and wraps modulo 2^CNT_W. illegalOp does not count.
- memRead/memWrite stay held while memReady=0; the stall length is unbounded.

Optional Feature:
- Macro UC_JUMP_EN.
- Defined: DECODE with opcode 000010 → JUMP. JUMP drives pcWrite=1, pcSrc=10, retire=1, then FETCH; latency 3 cycles.
- Undefined: state 11 is unreachable and 000010 is illegal (illegalOp=1, back to FETCH).

Decomposition:
- Package uc_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the 4-bit state encodings;
  - the aluOp, aluSrcB and pcSrc encodings.
- One sub-module, uc_out_decode: combinational state+memReady → control outputs. The top module holds the state register, next-state logic and counter.

Test Plan:
- rst=1 for 2 cycles → all control outputs 0, state=0, instrCount=0; release with memReady=1 → memRead=1, irWrite=1 in the first cycle.
- memReady=1, opcode=000000 → state sequence 0,1,6,7,0; regWrite=1 and regDst=1 only in state 7; retire once; instrCount=1.
- opcode=100011, memReady low 3 cycles in MEMRD → sequence 0,1,2,3,3,3,3,4,0; memRead and iorD held through the stall; memtoReg=1 in state 4.
- opcode=101011, then opcode=000100 → sw shows memWrite=1 and retire on its memReady cycle; beq shows pcWriteCond=1, pcSrc=01, aluOp=01 in state 8; instrCount=2.
- opcode=111111 → illegalOp=1 for one cycle in DECODE, next state 0, instrCount unchanged; repeat with 000010 under UC_JUMP_EN → state 11, pcWrite=1, pcSrc=10.
- rst asserted in MEMRD; separately, CNT_W=4 run of 17 instructions → state 0 and count 0 after reset; the counter wraps to 1.
